// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: memory-side bus shared by icache, dcache, memory and the arbiter
// Signals:
//   i_mem_*   icache refill request/address and returned data/valid
//   d_mem_*   dcache fill/store request, store data and returned data/valid
//   mem_*     single external memory port
//   grant_d   debug flag, high while the dcache owns the port
// Modports: slave = arbiter side, master = caches + memory side.
interface cache_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_mem_req;
    logic [ADDR_WIDTH-1:0] i_mem_addr;
    logic [DATA_WIDTH-1:0] i_mem_rdata;
    logic                  i_mem_valid;
    logic                  d_mem_req;
    logic                  d_mem_we;
    logic [ADDR_WIDTH-1:0] d_mem_addr;
    logic [DATA_WIDTH-1:0] d_mem_wdata;
    logic [DATA_WIDTH-1:0] d_mem_rdata;
    logic                  d_mem_valid;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_valid;
    logic                  grant_d;

    modport slave (
        input  i_mem_req, i_mem_addr, d_mem_req, d_mem_we, d_mem_addr, d_mem_wdata,
               mem_rdata, mem_valid,
        output i_mem_rdata, i_mem_valid, d_mem_rdata, d_mem_valid,
               mem_req, mem_we, mem_addr, mem_wdata, grant_d
    );

    modport master (
        output i_mem_req, i_mem_addr, d_mem_req, d_mem_we, d_mem_addr, d_mem_wdata,
               mem_rdata, mem_valid,
        input  i_mem_rdata, i_mem_valid, d_mem_rdata, d_mem_valid,
               mem_req, mem_we, mem_addr, mem_wdata, grant_d
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory port between icache refill and dcache fill/store engines
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bus   cache_mem_arbiter_if.slave (icache, dcache, memory port, grant_d debug)
// Grants last a whole transaction (BURST_LEN-beat fill or single-beat store) and
// always pass through IDLE for at least one cycle between owners.
// Build option ARB_RR_EN: round-robin arbitration; undefined = dcache has fixed priority.
module cache_mem_arbiter #(
    parameter int BURST_LEN  = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic                clk,
    input logic                rst,
    cache_mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(BURST_LEN);

    typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_cnt;
    logic                  r_single;
    logic                  w_pick_d;
    logic                  w_own_req;
    logic                  w_last;
    logic                  w_gi;
    logic                  w_gd;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

`ifdef ARB_RR_EN
    // 0 = icache preferred on a tie, 1 = dcache preferred
    logic r_ptr;
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= 1'b0;
        else if (r_state != IDLE && w_next == IDLE)
            r_ptr <= (r_state == GNT_I);
    end
    assign w_pick_d = bus.d_mem_req && (!bus.i_mem_req || r_ptr);
`else
    assign w_pick_d = bus.d_mem_req;
`endif

    assign w_gi = (r_state == GNT_I);
    assign w_gd = (r_state == GNT_D);

    always_comb begin
        w_own_req = w_gd ? bus.d_mem_req : bus.i_mem_req;
        w_last    = r_single || (r_cnt == CW'(BURST_LEN - 1));
        // Owner dropping req before its last beat aborts the grant
        w_next    = (r_state == IDLE) ?
                        ((bus.i_mem_req || bus.d_mem_req) ? (w_pick_d ? GNT_D : GNT_I) : IDLE) :
                    ((w_gi || w_gd) && w_own_req && !(bus.mem_valid && w_last)) ? r_state : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_single <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= (r_state == IDLE || w_next == IDLE) ? '0 : r_cnt + CW'(bus.mem_valid);
            if (r_state == IDLE)
                r_single <= w_pick_d && bus.d_mem_we;
        end
    end

    assign w_addr          = w_gd ? bus.d_mem_addr : bus.i_mem_addr;
    assign w_wdata         = bus.d_mem_wdata;
    assign bus.mem_req     = (w_gi && bus.i_mem_req) || (w_gd && bus.d_mem_req);
    assign bus.mem_we      = w_gd && bus.d_mem_we;
    assign bus.mem_addr    = w_addr;
    assign bus.mem_wdata   = w_wdata;
    assign bus.i_mem_valid = w_gi && bus.mem_valid;
    assign bus.d_mem_valid = w_gd && bus.mem_valid;
    assign bus.i_mem_rdata = bus.mem_rdata;
    assign bus.d_mem_rdata = bus.mem_rdata;
    assign bus.grant_d     = w_gd;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench for cache_mem_arbiter (honours ARB_RR_EN)
module tb_cache_mem_arbiter;
    typedef struct packed {
        logic        iv;
        logic        dv;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_en = 1'b0;
    int   passed = 0;
    int   total = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    cache_mem_arbiter #(.BURST_LEN(8), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Every cycle: a memory beat must reach exactly the expected port, otherwise no valid at all
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            total++;
            if (bus.mem_valid) begin
                if (sb.size() == 0) begin
                    $display("FAIL sb_empty: beat seen iv=%b dv=%b with nothing expected",
                             bus.i_mem_valid, bus.d_mem_valid);
                end else begin
                    e = sb.pop_front();
                    if ({bus.i_mem_valid, bus.d_mem_valid, bus.i_mem_rdata, bus.d_mem_rdata} !==
                        {e.iv, e.dv, e.data, e.data})
                        $display("FAIL beat: got iv=%b dv=%b ir=%h dr=%h want iv=%b dv=%b data=%h",
                                 bus.i_mem_valid, bus.d_mem_valid, bus.i_mem_rdata,
                                 bus.d_mem_rdata, e.iv, e.dv, e.data);
                    else
                        passed++;
                end
            end else if ({bus.i_mem_valid, bus.d_mem_valid} !== 2'b00) begin
                $display("FAIL spurious_valid: got iv=%b dv=%b want 00",
                         bus.i_mem_valid, bus.d_mem_valid);
            end else begin
                passed++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called right after the granting edge; drives n beats from the owner's side.
    task automatic serve(input logic exp_d, input logic [31:0] base, input int n,
                         input int gap, input logic last);
        logic [31:0] data;
        @(negedge clk);
        total++;
        if ({bus.mem_req, bus.grant_d} !== {1'b1, exp_d})
            $display("FAIL grant: got req=%b gd=%b want req=1 gd=%b",
                     bus.mem_req, bus.grant_d, exp_d);
        else
            passed++;
        for (int b = 0; b < n; b++) begin
            tick;
            bus.mem_valid = 1'b0;
            for (int g = 0; g < ((b % 2 == 1) ? gap : 0); g++) tick;
            if (exp_d) bus.d_mem_addr = base + 32'(4 * b);
            else bus.i_mem_addr = base + 32'(4 * b);
            data = base ^ 32'hA5A5_0000 ^ 32'(b);
            bus.mem_rdata = data;
            bus.mem_valid = 1'b1;
            sb.push_back({~exp_d, exp_d, data});
            @(negedge clk);
            total++;
            if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} !==
                {base + 32'(4 * b), exp_d & bus.d_mem_we, bus.d_mem_wdata})
                $display("FAIL fwd beat %0d: got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h",
                         b, bus.mem_addr, bus.mem_we, bus.mem_wdata, base + 32'(4 * b),
                         exp_d & bus.d_mem_we, bus.d_mem_wdata);
            else
                passed++;
        end
        tick;
        bus.mem_valid = 1'b0;
        if (last) begin
            @(negedge clk);
            total++;
            if ({bus.mem_req, bus.grant_d} !== 2'b00)
                $display("FAIL idle_after: got req=%b gd=%b want 00", bus.mem_req, bus.grant_d);
            else
                passed++;
        end
    endtask

    task automatic test_reset;
        bus.i_mem_req = 1'b1;
        bus.d_mem_req = 1'b1;
        bus.d_mem_we = 1'b1;
        bus.i_mem_addr = '0;
        bus.d_mem_addr = '0;
        bus.d_mem_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_valid = 1'b0;
        rst = 1'b1;
        tick;
        mon_en = 1'b1;
        tick;
        @(negedge clk);
        total++;
        if ({bus.mem_req, bus.mem_we, bus.i_mem_valid, bus.d_mem_valid, bus.grant_d} !== 5'b0)
            $display("FAIL reset_outputs: got %b want 00000",
                     {bus.mem_req, bus.mem_we, bus.i_mem_valid, bus.d_mem_valid, bus.grant_d});
        else
            passed++;
        bus.i_mem_req = 1'b0;
        bus.d_mem_req = 1'b0;
        bus.d_mem_we = 1'b0;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_icache_fill;
        bus.i_mem_req = 1'b1;
        tick;
        serve(1'b0, 32'h0000_2000, 8, 2, 1'b1);
        bus.i_mem_req = 1'b0;
        tick;
    endtask

    task automatic test_tie;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.i_mem_req = 1'b1;
        bus.d_mem_req = 1'b1;
        tick;
`ifdef ARB_RR_EN
        serve(1'b0, 32'h0000_5000, 8, 0, 1'b1);
        bus.i_mem_req = 1'b0;
        tick;
        serve(1'b1, 32'h0000_6000, 8, 0, 1'b1);
        bus.d_mem_req = 1'b0;
`else
        serve(1'b1, 32'h0000_6000, 8, 0, 1'b1);
        bus.d_mem_req = 1'b0;
        tick;
        serve(1'b0, 32'h0000_5000, 8, 0, 1'b1);
        bus.i_mem_req = 1'b0;
`endif
        tick;
    endtask

    task automatic test_store;
        bus.d_mem_we = 1'b1;
        bus.d_mem_wdata = 32'hDEAD_BEEF;
        bus.d_mem_req = 1'b1;
        tick;
        serve(1'b1, 32'h0000_1000, 1, 0, 1'b1);
        bus.d_mem_req = 1'b0;
        bus.d_mem_we = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        bus.d_mem_req = 1'b1;
        tick;
        bus.i_mem_req = 1'b1;
        serve(1'b1, 32'h0000_7000, 8, 0, 1'b1);
        tick;
`ifdef ARB_RR_EN
        serve(1'b0, 32'h0000_8000, 8, 0, 1'b1);
        bus.i_mem_req = 1'b0;
        tick;
        serve(1'b1, 32'h0000_9000, 8, 0, 1'b1);
        bus.d_mem_req = 1'b0;
`else
        serve(1'b1, 32'h0000_9000, 8, 0, 1'b1);
        bus.d_mem_req = 1'b0;
        tick;
        serve(1'b0, 32'h0000_8000, 8, 0, 1'b1);
        bus.i_mem_req = 1'b0;
`endif
        tick;
    endtask

    task automatic test_abort;
        bus.i_mem_req = 1'b1;
        tick;
        serve(1'b0, 32'h0000_A000, 3, 0, 1'b0);
        bus.i_mem_req = 1'b0;
        tick;
        @(negedge clk);
        total++;
        if ({bus.mem_req, bus.grant_d} !== 2'b00)
            $display("FAIL abort_idle: got req=%b gd=%b want 00", bus.mem_req, bus.grant_d);
        else
            passed++;
        tick;
        bus.mem_rdata = 32'h0BAD_F00D;
        bus.mem_valid = 1'b1;
        sb.push_back({1'b0, 1'b0, 32'h0BAD_F00D});
        tick;
        bus.mem_valid = 1'b0;
        bus.i_mem_req = 1'b1;
        tick;
        serve(1'b0, 32'h0000_B000, 8, 1, 1'b1);
        bus.i_mem_req = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_burst;
        bus.d_mem_req = 1'b1;
        tick;
        serve(1'b1, 32'h0000_C000, 4, 0, 1'b0);
        bus.d_mem_addr = 32'h0000_C010;
        bus.mem_rdata = 32'h5555_AAAA;
        bus.mem_valid = 1'b1;
        sb.push_back({1'b0, 1'b1, 32'h5555_AAAA});
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.mem_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.mem_req, bus.grant_d} !== 2'b00)
            $display("FAIL rst_mid_burst: got req=%b gd=%b want 00", bus.mem_req, bus.grant_d);
        else
            passed++;
        tick;
        serve(1'b1, 32'h0000_D000, 8, 0, 1'b1);
        bus.d_mem_req = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_icache_fill;
        test_tie;
        test_store;
        test_back_to_back;
        test_abort;
        test_reset_mid_burst;
        total++;
        if (sb.size() != 0)
            $display("FAIL sb_leftover: got %0d pending beats want 0", sb.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single external memory port between the instruction-cache refill engine and the data-cache refill/write-through engine. A grant is held for a whole transaction: a BURST_LEN-beat line fill, or a single-beat store. Grants are sequenced by a small registered FSM with a beat counter. The block sits between both caches' memory-side interfaces and the memory/bus interface unit.

## Interface
- BURST_LEN, 8: beats per line fill (words per line); power of two, ≥2
- ADDR_WIDTH, 32: address width
- DATA_WIDTH, 32: data width
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- i_mem_req  in  1  icache requests a line fill; held high until its last beat
- i_mem_addr  in  ADDR_WIDTH  icache beat address (icache advances it per beat)
- i_mem_rdata  out  DATA_WIDTH  read data to icache
- i_mem_valid  out  1  beat valid to icache
- d_mem_req  in  1  dcache transaction request; held until completion
- d_mem_we  in  1  1 = single-beat store, 0 = BURST_LEN-beat fill; sampled at grant
- d_mem_addr  in  ADDR_WIDTH  dcache beat address
- d_mem_wdata  in  DATA_WIDTH  store data
- d_mem_rdata  out  DATA_WIDTH  read data to dcache
- d_mem_valid  out  1  beat valid / store acknowledge to dcache
- mem_req  out  1  request to memory
- mem_we  out  1  write strobe to memory
- mem_addr  out  ADDR_WIDTH  address to memory
- mem_wdata  out  DATA_WIDTH  write data to memory
- mem_rdata  in  DATA_WIDTH  memory read data
- mem_valid  in  1  memory beat valid / write ack
- grant_d  out  1  debug: 1 while dcache owns the port

## Operation
- FSM states: IDLE, GNT_I, GNT_D. Encoding is 2-bit registered.
- IDLE: mem_req=0. On a clock edge with any request pending, the FSM chooses an owner (see Configuration). It enters GNT_I or GNT_D, latches the length (BURST_LEN, or 1 if d_mem_we=1 at that edge), and clears beat_cnt.
- GNT_x forwarding (combinational from the owner):
  - mem_req = x_mem_req.
  - mem_addr = x_mem_addr.
  - mem_we = d_mem_we in GNT_D, else 0.
  - mem_wdata = d_mem_wdata.
- The owner's x_mem_valid = mem_valid. The non-owner's x_mem_valid = 0. mem_rdata is broadcast to both rdata ports unconditionally.
- Each mem_valid in GNT_x increments beat_cnt. When mem_valid arrives with beat_cnt == length-1, the FSM returns to IDLE.
- Abort: if the owner drops its req while in GNT_x before the last beat, the FSM returns to IDLE next edge and beat_cnt clears. mem_valid arriving in IDLE is ignored; both x_mem_valid outputs stay 0.
- The FSM always passes through IDLE for ≥1 cycle between grants. This cycle is the requester's turnaround, since a cache drops its req the cycle after its last beat.
- beat_cnt is $clog2(BURST_LEN) bits and wraps silently. Length is compared, never overflowed.

## Timing
- Reset: state=IDLE, beat_cnt=0, rr pointer=icache. Outputs mem_req=0, mem_we=0, i_mem_valid=0, d_mem_valid=0, grant_d=0. mem_addr/mem_wdata reflect forwarding only.
- Grant latency: req high at edge N (FSM in IDLE) → mem_req=1 during cycle N+1.
- Fill duration: BURST_LEN mem_valid beats. The FSM is in IDLE the cycle after the beat that completes the transaction.
- Store: one mem_valid completes it. Minimum issue-to-issue spacing is 3 cycles (grant, ack, idle).
- Simultaneous i/d requests in IDLE: exactly one is granted, and the other waits in IDLE arbitration with its req held.
- Reset mid-burst: the FSM is in IDLE and mem_req=0 the cycle after rst is sampled high. Any in-flight beat is dropped.

## Configuration
- ARB_RR_EN defined: round-robin.
  - The 1-bit pointer flips to the other requester after each completed or aborted grant.
  - On a tie, the pointed-to requester wins.
  - A lone requester always wins.
- ARB_RR_EN undefined: fixed priority, dcache over icache. The pointer register is not built.

## Test plan
- Single icache fill, memory returns 8 beats with gaps → mem_addr follows i_mem_addr. i_mem_valid pulses 8×, d_mem_valid stays 0. The FSM is in IDLE the cycle after beat 8.
- Same-cycle i and d fill requests:
  - With ARB_RR_EN after reset → icache served first (8 beats), then dcache (8 beats).
  - Without ARB_RR_EN → dcache first.
- d store (d_mem_we=1, addr 0x1000, wdata 0xDEADBEEF) → mem_we=1 and mem_wdata=0xDEADBEEF for one grant. A single mem_valid completes it and produces one d_mem_valid pulse.
- Back-to-back d fills with icache pending, ARB_RR_EN defined → alternating grants d, i, d. There is no starvation, and a 1-cycle IDLE gap separates each grant.
- icache drops req after beat 3 → FSM goes to IDLE next cycle. A stray mem_valid in IDLE produces no valid pulse, and the next grant starts at beat_cnt=0.
- rst asserted during beat 5 of a dcache fill → mem_req=0, grant_d=0 next cycle. Fresh requests are then granted normally.
